// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR stage and its sequence checker:
// state type, checker FSM encoding, parasitic-cycle states and the next-state function.
package lfsr_pkg;

    typedef logic [3:0] lfsr_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        FAIL  = 2'd3
    } chk_state_t;

    // The XNOR-feedback LFSR has a lock-up pair outside the 14-state main cycle.
    localparam lfsr_state_t PARA_LO = 4'h5;
    localparam lfsr_state_t PARA_HI = 4'hA;

    function automatic lfsr_state_t lfsr4_next(input lfsr_state_t s);
        return {s[2] ^ ~(s[1] ^ s[0]), s[3:1]};
    endfunction

    function automatic logic is_parasitic(input lfsr_state_t s);
        return (s == PARA_LO) || (s == PARA_HI);
    endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Sample bus between the LFSR stage (master) and the sequence checker (slave),
// including the checker's status outputs and FSM state for observation.
interface lfsr_seq_checker_if #(
    parameter int CNT_W = 8
);
    import lfsr_pkg::*;

    // Handshake: en is a one-sided valid strobe; num is consumed on every rising
    // clk edge where en=1. There is no ready: the checker accepts every sample.
    logic             en;
    lfsr_state_t      num;
    logic             clear;

    logic             locked;
    logic             error_pulse;
    logic             fail;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             short_cycle;
    chk_state_t       state_dbg;

    modport master (
        output en, num, clear,
        input  locked, error_pulse, fail, err_cnt, period, period_valid,
               short_cycle, state_dbg
    );

    modport slave (
        input  en, num, clear,
        output locked, error_pulse, fail, err_cnt, period, period_valid,
               short_cycle, state_dbg
    );

endinterface

// File: rtl/lfsr_period_meter.sv
// Counts processed samples between recurrences of REF_STATE in the previous
// sample and publishes the distance as the sequence period.
module lfsr_period_meter
    import lfsr_pkg::*;
#(
    parameter lfsr_state_t REF_STATE = 4'h0,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_i,
    input  lfsr_state_t      prev_i,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o
);

    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] per_cnt_inc;
    logic [CNT_W-1:0] period_q;
    logic             period_valid_q;
    logic             have_ref_q;

    assign per_cnt_inc = (&per_cnt_q) ? per_cnt_q : per_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            per_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            have_ref_q     <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (sample_i) begin
                if (prev_i == REF_STATE) begin
                    // The first sighting only arms the meter; no period yet.
                    if (have_ref_q) begin
                        period_q       <= per_cnt_inc;
                        period_valid_q <= 1'b1;
                    end
                    per_cnt_q  <= '0;
                    have_ref_q <= 1'b1;
                end else begin
                    per_cnt_q <= per_cnt_inc;
                end
            end
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = period_valid_q;

endmodule

// File: rtl/lfsr_seq_checker.sv
// Monitors the 4-bit LFSR output: acquires lock on the recurrence, flags
// mismatches, latches failure, detects the parasitic 2-cycle and measures period.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter lfsr_state_t REF_STATE  = 4'h0,
    parameter int          LOCK_CNT   = 4,
    parameter int          ERR_THRESH = 2,
    parameter int          CNT_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    lfsr_seq_checker_if.slave   bus
);

    localparam logic [4:0] LOCK_LIM = 5'(LOCK_CNT);
    localparam logic [4:0] MISS_LIM = 5'(ERR_THRESH);

    chk_state_t       state_q;
    lfsr_state_t      prev_q;
    logic [3:0]       match_run_q;
    logic [3:0]       miss_run_q;
    logic             locked_q;
    logic             fail_q;
    logic             error_pulse_q;
    logic             short_cycle_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             match;
    logic [4:0]       match_run_inc;
    logic [4:0]       miss_run_inc;
    logic [CNT_W-1:0] err_cnt_inc;

    assign match         = (bus.num == lfsr4_next(prev_q));
    assign match_run_inc = {1'b0, match_run_q} + 5'd1;
    assign miss_run_inc  = {1'b0, miss_run_q} + 5'd1;
    assign err_cnt_inc   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            prev_q        <= '0;
            match_run_q   <= '0;
            miss_run_q    <= '0;
            locked_q      <= 1'b0;
            fail_q        <= 1'b0;
            error_pulse_q <= 1'b0;
            short_cycle_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            error_pulse_q <= 1'b0;
            if (bus.en) begin
                // prev always follows the real sequence so the checker resyncs.
                prev_q <= bus.num;
                unique case (state_q)
                    IDLE: state_q <= ACQ;
                    ACQ: begin
                        if (!match) begin
                            match_run_q <= '0;
                        end else if (match_run_inc >= LOCK_LIM) begin
                            state_q     <= TRACK;
                            locked_q    <= 1'b1;
                            match_run_q <= '0;
                        end else begin
                            match_run_q <= match_run_inc[3:0];
                        end
                    end
                    TRACK: begin
                        if (match) begin
                            miss_run_q <= '0;
                        end else begin
                            error_pulse_q <= 1'b1;
                            err_cnt_q     <= err_cnt_inc;
                            if (miss_run_inc >= MISS_LIM) begin
                                state_q    <= FAIL;
                                locked_q   <= 1'b0;
                                fail_q     <= 1'b1;
                                miss_run_q <= '0;
                            end else begin
                                miss_run_q <= miss_run_inc[3:0];
                            end
                        end
                    end
                    FAIL: begin
                        if (!match) begin
                            error_pulse_q <= 1'b1;
                            err_cnt_q     <= err_cnt_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                if (state_q != IDLE && is_parasitic(bus.num)) begin
                    short_cycle_q <= 1'b1;
                end
            end
            // Placed last so clear overrides any same-edge error count or FSM move.
            if (bus.clear) begin
                err_cnt_q     <= '0;
                short_cycle_q <= 1'b0;
                if (state_q == FAIL) begin
                    state_q     <= ACQ;
                    fail_q      <= 1'b0;
                    match_run_q <= '0;
                    miss_run_q  <= '0;
                end
            end
        end
    end

    lfsr_period_meter #(
        .REF_STATE (REF_STATE),
        .CNT_W     (CNT_W)
    ) u_period (
        .clk            (clk),
        .reset          (reset),
        .sample_i       (bus.en && (state_q != IDLE)),
        .prev_i         (prev_q),
        .period_o       (bus.period),
        .period_valid_o (bus.period_valid)
    );

    assign bus.locked      = locked_q;
    assign bus.fail        = fail_q;
    assign bus.error_pulse = error_pulse_q;
    assign bus.short_cycle = short_cycle_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: vector table of samples with hand-derived
// expectations, plus explicit sequences for saturation and clear-with-mismatch.
module tb_lfsr_seq_checker;
    import lfsr_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_seq_checker_if #(.CNT_W(8)) bus ();

    lfsr_seq_checker #(
        .REF_STATE  (4'h0),
        .LOCK_CNT   (4),
        .ERR_THRESH (2),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] num;
        logic       clr;
        logic       locked;
        logic       ep;
        logic       fail;
        logic [7:0] err_cnt;
        logic [7:0] period;
        logic       pv;
        logic       short_c;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    logic [3:0] main_seq [14] = '{4'h0, 4'h8, 4'hC, 4'h6, 4'hB, 4'hD, 4'hE,
                                  4'hF, 4'h7, 4'h3, 4'h9, 4'h4, 4'h2, 4'h1};

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void add(input logic rst_n, input logic en, input logic [3:0] num,
                                input logic clr, input logic locked, input logic ep,
                                input logic fail, input int err_cnt, input int period,
                                input logic pv, input logic short_c);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.num = num; v.clr = clr;
        v.locked = locked; v.ep = ep; v.fail = fail;
        v.err_cnt = 8'(err_cnt); v.period = 8'(period);
        v.pv = pv; v.short_c = short_c;
        tbl.push_back(v);
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic en, input logic [3:0] num, input logic clr);
        bus.en    = en;
        bus.num   = num;
        bus.clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string tag, input vec_t v);
        check({tag, ".locked"},       int'(bus.locked),       int'(v.locked));
        check({tag, ".error_pulse"},  int'(bus.error_pulse),  int'(v.ep));
        check({tag, ".fail"},         int'(bus.fail),         int'(v.fail));
        check({tag, ".err_cnt"},      int'(bus.err_cnt),      int'(v.err_cnt));
        check({tag, ".period"},       int'(bus.period),       int'(v.period));
        check({tag, ".period_valid"}, int'(bus.period_valid), int'(v.pv));
        check({tag, ".short_cycle"},  int'(bus.short_cycle),  int'(v.short_c));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t zero_v;
        int   exp_err;

        reset     = 1'b0;
        bus.en    = 1'b0;
        bus.num   = 4'h0;
        bus.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        zero_v = '{rst_n: 1'b0, en: 1'b0, num: 4'h0, clr: 1'b0, locked: 1'b0, ep: 1'b0,
                   fail: 1'b0, err_cnt: 8'd0, period: 8'd0, pv: 1'b0, short_c: 1'b0};
        check_row("reset", zero_v);
        check("reset.state", int'(bus.state_dbg), int'(IDLE));
        reset = 1'b1;

        // Main cycle: lock after seed + 4 matches, period 14 from sample 16.
        for (int k = 1; k <= 30; k++)
            add(1, 1, main_seq[(k - 1) % 14], 0, k >= 5, 0, 0, 0,
                (k >= 16) ? 14 : 0, (k == 16) || (k == 30), 0);
        add(1, 1, 4'hC, 0, 1, 0, 0, 0, 14, 0, 0);
        // 7 instead of 6: single miss, stays locked; then follow f(7)=3 onward.
        add(1, 1, 4'h7, 0, 1, 1, 0, 1, 14, 0, 0);
        add(1, 1, 4'h3, 0, 1, 0, 0, 1, 14, 0, 0);
        add(1, 1, 4'h9, 0, 1, 0, 0, 1, 14, 0, 0);
        add(1, 1, 4'h4, 0, 1, 0, 0, 1, 14, 0, 0);
        add(1, 1, 4'h2, 0, 1, 0, 0, 1, 14, 0, 0);
        add(1, 1, 4'h1, 0, 1, 0, 0, 1, 14, 0, 0);
        add(1, 1, 4'h0, 0, 1, 0, 0, 1, 14, 0, 0);
        // Clear while tracking; shortened loop gives period 9.
        add(1, 1, 4'h8, 1, 1, 0, 0, 0, 9, 1, 0);
        // Two consecutive misses -> FAIL.
        add(1, 1, 4'h0, 0, 1, 1, 0, 1, 9, 0, 0);
        add(1, 1, 4'h0, 0, 0, 1, 1, 2, 2, 1, 0);
        // Clear out of FAIL, reacquire over 4 matches.
        add(1, 1, 4'h8, 1, 0, 0, 0, 0, 1, 1, 0);
        add(1, 1, 4'hC, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 4'h6, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 4'hB, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 4'hD, 0, 1, 0, 0, 0, 1, 0, 0);
        // en=0 with garbage: nothing moves.
        add(1, 0, 4'h5, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 4'h3, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 1, 4'hE, 0, 1, 0, 0, 0, 1, 0, 0);
        // Reset while locked.
        add(0, 1, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0);
        // Parasitic 2-cycle: locks, sets short_cycle, never a period.
        add(1, 1, 4'hA, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4'h5, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 4'hA, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 4'h5, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 4'hA, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 4'h5, 0, 1, 0, 0, 0, 0, 0, 1);
        // Reset, lock, then drive into FAIL for the saturation run.
        add(0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4'hC, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4'h6, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4'hB, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 4'h0, 0, 0, 1, 1, 2, 5, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst_n;
            step(tbl[i].en, tbl[i].num, tbl[i].clr);
            check_row($sformatf("row%0d", i), tbl[i]);
        end
        reset = 1'b1;

        // 300 mismatches in FAIL: err_cnt climbs to 255 and holds.
        exp_err = 2;
        for (int i = 0; i < 300; i++) begin
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
            exp_q.push_back(8'(exp_err));
            step(1'b1, 4'h0, 1'b0);
            check($sformatf("sat%0d.err_cnt", i), int'(bus.err_cnt), int'(exp_q.pop_front()));
        end
        check("sat.fail", int'(bus.fail), 1);
        check("sat.error_pulse", int'(bus.error_pulse), 1);

        // clear on the same edge as a mismatch: count zeroed, FAIL -> ACQ.
        step(1'b1, 4'h0, 1'b1);
        check("clrmiss.err_cnt", int'(bus.err_cnt), 0);
        check("clrmiss.fail", int'(bus.fail), 0);
        check("clrmiss.locked", int'(bus.locked), 0);
        check("clrmiss.state", int'(bus.state_dbg), int'(ACQ));
        step(1'b1, 4'h8, 1'b0);
        check("reacq1.locked", int'(bus.locked), 0);
        step(1'b1, 4'hC, 1'b0);
        check("reacq2.locked", int'(bus.locked), 0);
        step(1'b1, 4'h6, 1'b0);
        check("reacq3.locked", int'(bus.locked), 0);
        step(1'b1, 4'hB, 1'b0);
        check("reacq4.locked", int'(bus.locked), 1);
        check("reacq4.state", int'(bus.state_dbg), int'(TRACK));

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream consumer of the 4-bit LFSR stage: samples its 4-bit state and checks each sample against the LFSR recurrence.
- Detects loss of lock, the parasitic 2-state cycle, and measures sequence period.
- Serves as the self-test/monitor stage on the LFSR output bus.
- The LFSR updates on falling clk edges; this block samples on rising clk edges, mid-cycle, so the data is stable.

Parameters:
- REF_STATE, 4'h0, state whose recurrence delimits one period measurement.
- LOCK_CNT, 4, consecutive matching samples required to assert locked (1..15).
- ERR_THRESH, 2, consecutive mismatches while locked that force FAIL (1..15).
- CNT_W, 8, width of err_cnt and period.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-low.
- en  in  1  sample strobe; num is consumed only when en=1.
- num  in  4  LFSR state {b3,b2,b1,b0}.
- clear  in  1  synchronous clear of FAIL, err_cnt and short_cycle; prev sample and period counter kept.
- locked  out  1  high in TRACK state.
- error_pulse  out  1  one-cycle pulse per mismatching sample in TRACK or FAIL.
- fail  out  1  high in FAIL state (sticky).
- err_cnt  out  CNT_W  saturating count of mismatches.
- period  out  CNT_W  last measured period in samples.
- period_valid  out  1  one-cycle pulse when period updates.
- short_cycle  out  1  sticky; set when a sample equals 4'h5 or 4'hA.

Behaviour:
- Recurrence: exp = f(prev).
  - exp[3] = prev[2] ^ ~(prev[1] ^ prev[0]).
  - exp[2] = prev[3], exp[1] = prev[2], exp[0] = prev[1].
- Main cycle (14 states): 0,8,C,6,B,D,E,F,7,3,9,4,2,1,0.
- Parasitic 2-cycle: 5<->A.
- Reset (reset=0 at a rising edge):
  - state=IDLE.
  - prev=0, match_run=0, miss_run=0, per_cnt=0, have_ref=0.
  - All outputs 0.
- All registers hold when en=0; a sample is processed only on an edge with en=1.
- FSM:
  - IDLE: first sample loads prev; go ACQ; no compare.
  - ACQ: compare num against f(prev).
    - Match: match_run++.
    - Mismatch: match_run=0; no error_pulse, no err_cnt change.
    - When match_run reaches LOCK_CNT, go TRACK (locked=1 the cycle after the LOCK_CNT-th match).
  - TRACK:
    - Match: miss_run=0.
    - Mismatch: error_pulse=1, err_cnt++ (saturating at all-ones), miss_run++.
    - When miss_run reaches ERR_THRESH, go FAIL.
  - FAIL: fail=1, locked=0; mismatches still pulse error_pulse and increment err_cnt.
    - clear=1: go ACQ with match_run=0, miss_run=0.
- prev is updated with num on every processed sample, match or not; resync follows the actual sequence.
- Period:
  - Condition: prev==REF_STATE on a processed sample. If have_ref=1, period<=per_cnt+1 and period_valid=1. Then per_cnt<=0 and have_ref<=1.
  - Otherwise per_cnt increments, saturating at all-ones.
  - Expected period on the main cycle: 14.
- short_cycle sets on any processed sample equal to 5 or A, in every state except IDLE; it clears only via clear or reset.
- clear and a mismatch on the same edge: the clear takes precedence for err_cnt (result 0); the FSM still goes FAIL->ACQ.
- Reset mid-operation: takes effect at the next rising edge regardless of en or clear.
- All outputs are registered; latency is 1 clk from the sampling edge.

Decomposition:
- Shared package lfsr_pkg holds:
  - 4-bit state typedef.
  - FSM enum: IDLE, ACQ, TRACK, FAIL.
  - Parasitic-cycle constants 4'h5 and 4'hA.
  - Function lfsr4_next() implementing f(); the LFSR and the checker both use it.
- One natural sub-module: lfsr_period_meter (per_cnt, have_ref, period, period_valid).

Test Plan:
- Reset, then en=1 feeding 0,8,C,6,B,D,E,F,7,3,9,4,2,1,0,8... -> locked=1 after the 5th sample (1 seed + 4 matches); err_cnt=0, fail=0. First period_valid follows the second appearance of 0 with period=14, then repeats every 14 samples.
- While locked, replace one sample 6 with 7, then continue correctly -> one error_pulse, err_cnt=1, locked stays 1 (miss_run 1 < 2).
- While locked, feed two consecutive wrong samples -> err_cnt=2, fail=1, locked=0. Then clear=1 for one cycle -> err_cnt=0, fail=0, ACQ; locked returns after 4 matching samples.
- After seed, feed 5,A,5,A... -> short_cycle=1 from the first 5 and stays set; locked asserts after 4 matches, since the recurrence holds on the 2-cycle. No period_valid (REF_STATE never seen).
- Toggle en=0 for 3 cycles mid-sequence with num garbage -> no state change, no error_pulse. Pull reset=0 for one edge while locked -> all outputs 0 next cycle.
- Force 300 mismatches in FAIL -> err_cnt saturates at 255 without wrap.
